chunked_magnitude_comparator: RTL and testbench

//   Multi-cycle unsigned magnitude comparator for wide operands, e.g. a block

---
 rtl/chunked_magnitude_comparator.sv | 70 +++++++
 tb/tb_chunked_magnitude_comparator.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/chunked_magnitude_comparator.sv
// chunked_magnitude_comparator: multi-cycle unsigned A vs B compare, CHUNK bits per cycle, MSB first, early exit
// ports: clk, rst_n (async, active-low); in_valid/in_ready + a/b accept operands in IDLE;
//        out_valid/out_ready hand over one-hot greater/equal/less, held in DONE until consumed
module chunked_magnitude_comparator #(
  parameter int WIDTH = 256,
  parameter int CHUNK = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             greater,
  output logic             equal,
  output logic             less
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMP  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [IDXW-1:0] idx;
  logic [WIDTH-1:0] ra, rb;
  logic [CHUNK-1:0] ca, cb;
  logic last;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign ca = ra[WIDTH-1-int'(idx)*CHUNK -: CHUNK];
  assign cb = rb[WIDTH-1-int'(idx)*CHUNK -: CHUNK];
  assign last = idx == IDXW'(NCHUNK-1);
  // operands need no reset; they are only captured on accept
  always_ff @(posedge clk)
    if (in_ready && in_valid) begin
      ra <= a;
      rb <= b;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      greater <= 1'b0;
      equal <= 1'b0;
      less <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        idx <= '0;
        state <= CMP;
      end
    end else if (state == CMP) begin
      if (ca != cb) begin
        greater <= ca > cb;
        less <= ca < cb;
        state <= DONE;
      end else if (last) begin
        equal <= 1'b1;
        state <= DONE;
      end else begin
        idx <= idx + 1'b1;
      end
    end else if (out_ready) begin
      greater <= 1'b0;
      equal <= 1'b0;
      less <= 1'b0;
      state <= IDLE;
    end
endmodule

// File: tb/tb_chunked_magnitude_comparator.sv
// tb_chunked_magnitude_comparator: random and directed checks of both a 256/32 and an 8/8 instance against an arithmetic model
module tb_chunked_magnitude_comparator;
  localparam int W = 256;
  localparam int C = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, greater, equal, less;
  logic s_in_valid = 1'b0, s_out_ready = 1'b1;
  logic [7:0] s_a = '0, s_b = '0;
  logic s_in_ready, s_out_valid, s_greater, s_equal, s_less;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  chunked_magnitude_comparator #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .greater(greater), .equal(equal), .less(less)
  );
  chunked_magnitude_comparator #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .a(s_a), .b(s_b),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .greater(s_greater), .equal(s_equal), .less(s_less)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [W-1:0] rnd256();
    logic [W-1:0] r = '0;
    for (int i = 0; i < W / 32; i++) r = (r << 32) | W'($urandom);
    return r;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [W-1:0] va, input logic [W-1:0] vb, input int stall);
    int lat, n;
    logic [2:0] flags;
    lat = W / C;
    for (int k = W / C - 1; k >= 0; k--)
      if (((va ^ vb) >> (W - (k + 1) * C)) != 0) lat = k + 1;
    out_ready = stall == 0;
    a = va;
    b = vb;
    in_valid = 1'b1;
    chk("in_ready_idle", 64'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    a = rnd256();
    b = rnd256();
    n = 0;
    while (!out_valid && n < 20) begin
      chk("flags_zero_cmp", {greater, equal, less}, 0);
      tick();
      n++;
    end
    chk("latency", n, lat);
    chk("greater", 64'(greater), 64'(va > vb));
    chk("equal", 64'(equal), 64'(va == vb));
    chk("less", 64'(less), 64'(va < vb));
    chk("onehot", 64'(greater) + 64'(equal) + 64'(less), 1);
    flags = {greater, equal, less};
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom);
      a = rnd256();
      b = rnd256();
      tick();
      chk("stall_valid", 64'(out_valid), 1);
      chk("stall_in_ready", 64'(in_ready), 0);
      chk("stall_flags", {greater, equal, less}, 64'(flags));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("done_to_idle_valid", 64'(out_valid), 0);
    chk("done_to_idle_ready", 64'(in_ready), 1);
    chk("done_to_idle_flags", {greater, equal, less}, 0);
  endtask
  initial begin
    logic [W-1:0] va, vb, m;
    logic [7:0] vals [6] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF};
    #12;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_flags", {greater, equal, less}, 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    rst_n = 1'b1;
    tick();
    va = {32{8'hA5}};
    run(va, va, 0);
    run(W'(32'h8000_0000) << 224, W'(32'h7FFF_FFFF) << 224, 0);
    va = rnd256();
    run((va & ~W'(32'hFFFF_FFFF)) | W'(1), (va & ~W'(32'hFFFF_FFFF)) | W'(2), 0);
    run(rnd256(), rnd256(), 5);
    run(W'(7), W'(3), 0);
    va = rnd256();
    a = va;
    b = va ^ W'(1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 64'(out_valid), 0);
    chk("abort_flags", {greater, equal, less}, 0);
    chk("abort_in_ready", 64'(in_ready), 1);
    repeat (10) begin
      tick();
      chk("abort_no_pulse", 64'(out_valid), 0);
    end
    rst_n = 1'b1;
    tick();
    chk("post_abort_ready", 64'(in_ready), 1);
    run(W'(5), W'(9), 0);
    for (int t = 0; t < 40; t++) begin
      va = rnd256();
      vb = rnd256();
      if (t % 4 != 0) begin
        int j = $urandom_range(W / C - 1);
        m = (W'(1) << (j * C)) - 1;
        vb = va ^ (W'(32'($urandom) | 32'h1) << (j * C)) ^ (rnd256() & m);
      end
      if (t % 7 == 0) vb = va;
      run(va, vb, $urandom_range(3));
    end
    foreach (vals[i])
      foreach (vals[j]) begin
        s_a = vals[i];
        s_b = vals[j];
        s_in_valid = 1'b1;
        chk("s_in_ready", 64'(s_in_ready), 1);
        tick();
        s_in_valid = 1'b0;
        chk("s_cmp_not_valid", 64'(s_out_valid), 0);
        tick();
        chk("s_valid_lat1", 64'(s_out_valid), 1);
        chk("s_flags", {s_greater, s_equal, s_less},
            {61'd0, vals[i] > vals[j], vals[i] == vals[j], vals[i] < vals[j]});
        chk("s_onehot", 64'(s_greater) + 64'(s_equal) + 64'(s_less), 1);
        tick();
        chk("s_back_idle", 64'(s_in_ready), 1);
      end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
